dev_req_arbiter: RTL



---
 rtl/dev_req_arbiter_pkg.sv | 19 +
 rtl/dev_req_arbiter_rr_pick.sv | 39 +++
 rtl/dev_req_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dev_req_arbiter_pkg.sv
// Shared types and widths for the device-port request arbiter.
package dev_arb_pkg;

    localparam int DEV_ADDR_W = 32;
    localparam int DEV_DATA_W = 32;
    localparam int DEV_BE_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOCK = 2'd1,
        S_RSP  = 2'd2
    } state_e;

    // Successor of idx in a ring of n requesters.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dev_req_arbiter_rr_pick.sv
// Combinational winner selection: round-robin from rr_ptr, or strict lowest-index
// priority when DEV_REQ_ARB_FIXED_PRIO_EN is defined.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

`ifdef DEV_REQ_ARB_FIXED_PRIO_EN
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;

    always_comb begin
        winner  = '0;
        any_req = |req;
        // Scan downward so the lowest asserted index is the last one written.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) winner = IDX_W'(i);
        end
    end
`else
    always_comb begin
        int idx;
        winner  = '0;
        any_req = |req;
        idx     = 0;
        // Scan offsets downward so the nearest requester at or after rr_ptr wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (req[idx]) winner = IDX_W'(idx);
        end
    end
`endif

endmodule

// File: rtl/dev_req_arbiter.sv
// Shares one req/gnt/rvalid device port among N_REQ requesters, single outstanding
// transaction. Define DEV_REQ_ARB_FIXED_PRIO_EN for strict requester-0 priority.
module dev_req_arbiter
    import dev_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          up_req_i,
    input  logic [N_REQ*DEV_ADDR_W-1:0] up_addr_i,
    input  logic [N_REQ-1:0]          up_we_i,
    input  logic [N_REQ*DEV_BE_W-1:0] up_be_i,
    input  logic [N_REQ*DEV_DATA_W-1:0] up_wdata_i,
    output logic [N_REQ-1:0]          up_gnt_o,
    output logic [N_REQ-1:0]          up_rvalid_o,
    output logic [N_REQ-1:0]          up_err_o,
    output logic [DEV_DATA_W-1:0]     up_rdata_o,
    output logic                      dn_req_o,
    output logic [DEV_ADDR_W-1:0]     dn_addr_o,
    output logic                      dn_we_o,
    output logic [DEV_BE_W-1:0]       dn_be_o,
    output logic [DEV_DATA_W-1:0]     dn_wdata_o,
    input  logic                      dn_gnt_i,
    input  logic                      dn_rvalid_i,
    input  logic                      dn_err_i,
    input  logic [DEV_DATA_W-1:0]     dn_rdata_i
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e           state, state_n;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
    logic [IDX_W-1:0] owner, owner_n;
    logic [IDX_W-1:0] lock_idx, lock_n;
    logic [IDX_W-1:0] winner, sel_idx;
    logic             any_req, drive_dn;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (up_req_i),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            lock_idx <= '0;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_ptr_n;
            owner    <= owner_n;
            lock_idx <= lock_n;
        end
    end

    // NOTE: every signal written here is given a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        owner_n     = owner;
        lock_n      = lock_idx;
        sel_idx     = '0;
        drive_dn    = 1'b0;
        dn_req_o    = 1'b0;
        up_gnt_o    = '0;
        up_rvalid_o = '0;
        up_err_o    = '0;
        up_rdata_o  = '0;

        // Outputs are forced quiet while reset is held, even mid-transaction.
        if (rst_n) begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        drive_dn = 1'b1;
                        sel_idx  = winner;
                        dn_req_o = 1'b1;
                        if (dn_gnt_i) begin
                            up_gnt_o[winner] = 1'b1;
                            owner_n          = winner;
                            state_n          = S_RSP;
                        end else begin
                            lock_n  = winner;
                            state_n = S_LOCK;
                        end
                    end
                end
                S_LOCK: begin
                    drive_dn = 1'b1;
                    sel_idx  = lock_idx;
                    dn_req_o = up_req_i[lock_idx];
                    if (!up_req_i[lock_idx]) begin
                        state_n = S_IDLE;
                    end else if (dn_gnt_i) begin
                        up_gnt_o[lock_idx] = 1'b1;
                        owner_n            = lock_idx;
                        state_n            = S_RSP;
                    end
                end
                S_RSP: begin
                    if (dn_rvalid_i) begin
                        up_rvalid_o[owner] = 1'b1;
                        up_err_o[owner]    = dn_err_i;
                        up_rdata_o         = dn_rdata_i;
`ifdef DEV_REQ_ARB_FIXED_PRIO_EN
                        rr_ptr_n           = '0;
`else
                        rr_ptr_n           = IDX_W'(wrap_inc(int'(owner), N_REQ));
`endif
                        state_n            = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign dn_addr_o  = drive_dn ? up_addr_i[int'(sel_idx)*DEV_ADDR_W +: DEV_ADDR_W] : '0;
    assign dn_we_o    = drive_dn ? up_we_i[sel_idx] : 1'b0;
    assign dn_be_o    = drive_dn ? up_be_i[int'(sel_idx)*DEV_BE_W +: DEV_BE_W] : '0;
    assign dn_wdata_o = drive_dn ? up_wdata_i[int'(sel_idx)*DEV_DATA_W +: DEV_DATA_W] : '0;

endmodule
